// File: rtl/pl_mem_pkg.sv
// Shared types and constants for the memory-access pipeline stage.
package pl_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] RESULT_SRC_MEM = 2'b01;

endpackage

// File: rtl/pl_mem_stage_fmt.sv
// pl_mem_fmt: combinational store lane steering / byte enables, load extraction / extension,
// and misalignment detection for the memory stage.
module pl_mem_fmt
    import pl_mem_pkg::*;
(
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [1:0]  req_offset,
    input  logic [31:0] st_data,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata,
    output logic        misaligned,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_offset,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    logic [1:0]  req_size;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        st_be    = 4'hF;
        st_wdata = st_data;
        case (req_funct3)
            F3_B: begin
                st_be    = 4'b0001 << req_offset;
                st_wdata = {4{st_data[7:0]}};
            end
            F3_H: begin
                st_be    = 4'b0011 << {req_offset[1], 1'b0};
                st_wdata = {2{st_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Stores only know SB/SH as narrow sizes; loads treat the unsigned variants as narrow too.
    always_comb begin
        if (req_store)
            req_size = (req_funct3 == F3_B) ? 2'd0 : (req_funct3 == F3_H) ? 2'd1 : 2'd2;
        else
            req_size = req_funct3[1] ? 2'd2 : {1'b0, req_funct3[0]};
        misaligned = ((req_size == 2'd1) && req_offset[0]) ||
                     ((req_size == 2'd2) && (req_offset != 2'b00));
    end

    always_comb begin
        ld_byte = ld_rdata[{ld_offset, 3'b000} +: 8];
        ld_half = ld_offset[1] ? ld_rdata[31:16] : ld_rdata[15:0];
        case (ld_funct3)
            F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            F3_BU:   ld_data = {24'd0, ld_byte};
            F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
            F3_HU:   ld_data = {16'd0, ld_half};
            default: ld_data = ld_rdata;
        endcase
    end

endmodule

// File: rtl/pl_mem_stage.sv
// Memory-access pipeline stage: req/ack handshake with variable-latency memory and watchdog.
// Optional misaligned-access trap enabled by defining PL_MEM_MISALIGN_TRAP_EN.
module pl_mem_stage
    import pl_mem_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] ALUResultM,
    input  logic [XLEN-1:0] WriteDataM,
    input  logic [2:0]      funct3M,
    input  logic            MemWriteM,
    input  logic [1:0]      ResultSrcM,
    output logic [XLEN-1:0] ReadDataM,
    output logic            StallM,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_be,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ack,
    output logic            bus_err,
    output logic            misalign
);

`ifdef PL_MEM_MISALIGN_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t          state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [2:0]      lat_funct3;
    logic [1:0]      lat_offset;
    logic            access, trap, timeout;
    logic [3:0]      st_be;
    logic [31:0]     st_wdata, ld_data;
    logic            misaligned;

    assign access  = MemWriteM | (ResultSrcM == RESULT_SRC_MEM);
    assign StallM  = access & (state != DONE);
    assign trap    = TRAP_EN & misaligned;
    assign timeout = (TIMEOUT_CYCLES != 0) && (state == BUSY) && (cnt == CNT_LAST) && !mem_ack;

    pl_mem_fmt u_fmt (
        .req_store  (MemWriteM),
        .req_funct3 (funct3M),
        .req_offset (ALUResultM[1:0]),
        .st_data    (WriteDataM),
        .st_be      (st_be),
        .st_wdata   (st_wdata),
        .misaligned (misaligned),
        .ld_funct3  (lat_funct3),
        .ld_offset  (lat_offset),
        .ld_rdata   (mem_rdata),
        .ld_data    (ld_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (access) state_next = trap ? DONE : BUSY;
            BUSY:    if (mem_ack || timeout) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ReadDataM  <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_be     <= '0;
            bus_err    <= 1'b0;
            misalign   <= 1'b0;
            cnt        <= '0;
            lat_funct3 <= '0;
            lat_offset <= '0;
        end else begin
            misalign <= 1'b0;
            case (state)
                IDLE: begin
                    if (access && trap) begin
                        ReadDataM <= '0;
                        misalign  <= 1'b1;
                    end else if (access) begin
                        mem_req    <= 1'b1;
                        mem_we     <= MemWriteM;
                        mem_addr   <= {ALUResultM[XLEN-1:2], 2'b00};
                        mem_wdata  <= st_wdata;
                        mem_be     <= MemWriteM ? st_be : 4'hF;
                        cnt        <= '0;
                        lat_funct3 <= funct3M;
                        lat_offset <= ALUResultM[1:0];
                    end
                end
                BUSY: begin
                    cnt <= cnt + 1'b1;
                    // An ack arriving on the final watchdog cycle still completes normally.
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (!mem_we) ReadDataM <= ld_data;
                    end else if (timeout) begin
                        mem_req   <= 1'b0;
                        bus_err   <= 1'b1;
                        ReadDataM <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pl_mem_stage.sv
// Self-checking bench for pl_mem_stage: directed vector table, corner sequences, random vs model.
// Follows PL_MEM_MISALIGN_TRAP_EN when the design is built with it.
module tb_pl_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ALUResultM, WriteDataM, ReadDataM, mem_addr, mem_wdata, mem_rdata;
    logic [2:0]  funct3M;
    logic        MemWriteM, StallM, mem_req, mem_we, mem_ack, bus_err, misalign;
    logic [1:0]  ResultSrcM;
    logic [3:0]  mem_be;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pl_mem_stage #(.XLEN(32), .TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .funct3M    (funct3M),
        .MemWriteM  (MemWriteM),
        .ResultSrcM (ResultSrcM),
        .ReadDataM  (ReadDataM),
        .StallM     (StallM),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .bus_err    (bus_err),
        .misalign   (misalign)
    );

    typedef struct {
        logic        we;
        logic [1:0]  rs;
        logic [2:0]  f3;
        logic [31:0] a, wd, rd;
        int          lat;
        logic [31:0] exp_rd;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd, exp_addr;
        int          exp_stalls;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Access size in bytes as the memory stage sees it.
    function automatic int acc_size(input logic is_store, input logic [2:0] f3);
        if (is_store) return (f3 == 3'b000) ? 1 : (f3 == 3'b001) ? 2 : 4;
        return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        int sz = acc_size(1'b0, f3);
        int off = (int'(a[1:0]) / sz) * sz;
        logic [31:0] v = rd >> (8 * off);
        logic [31:0] mask;
        if (sz == 4) return v;
        mask = (32'd1 << (8 * sz)) - 32'd1;
        v = v & mask;
        if (!f3[2] && v[8*sz-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                             output logic [3:0] be, output logic [31:0] wdata);
        int sz = acc_size(1'b1, f3);
        int off = (int'(a[1:0]) / sz) * sz;
        logic [3:0] lanes = 4'((1 << sz) - 1);
        be = (sz == 4) ? 4'hF : 4'(lanes << off);
        for (int i = 0; i < 4; i++) wdata[8*i +: 8] = wd[8*(i % sz) +: 8];
    endtask

    // Drives one access starting in IDLE; ack comes on BUSY cycle `lat` (0 = never).
    // Returns in the following IDLE cycle with the access inputs dropped.
    task automatic do_access(input logic we, input logic [1:0] rs, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                             input int lat, output int stalls, output int req_cycles,
                             output logic [3:0] be, output logic [31:0] wdv, output logic [31:0] addrv,
                             output logic mis);
        MemWriteM = we; ResultSrcM = rs; funct3M = f3; ALUResultM = a; WriteDataM = wd;
        mem_rdata = rd; mem_ack = 1'b0;
        stalls = 0; req_cycles = 0; be = '0; wdv = '0; addrv = '0; mis = 1'b0;
        for (int c = 0; c < 100; c++) begin
            #1;
            if (!StallM) begin
                mis = misalign;
                break;
            end
            stalls++;
            if (mem_req) begin
                req_cycles++;
                be = mem_be; wdv = mem_wdata; addrv = mem_addr;
                mem_ack = (req_cycles == lat);
            end
            @(negedge clk);
            mem_ack = 1'b0;
        end
        MemWriteM = 1'b0; ResultSrcM = 2'b00;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int stalls, reqs;
        logic [3:0] be, m_be;
        logic [31:0] wdv, addrv, m_wd, mdl_rd, rd;
        logic mis, we, is_mis;
        logic [1:0] rs;
        logic [2:0] f3;
        logic [31:0] a, wd;
        int lat, sz;

        vecs[0] = '{1'b1, 2'b00, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0,      3, 32'h00000000, 4'hF,    32'hDEADBEEF, 32'h100, 4};
        vecs[1] = '{1'b0, 2'b01, 3'b000, 32'h203, 32'h0,        32'h80FF1234, 1, 32'hFFFFFF80, 4'hF,  32'h0,        32'h200, 2};
        vecs[2] = '{1'b0, 2'b01, 3'b101, 32'h202, 32'h0,        32'h80FF1234, 1, 32'h000080FF, 4'hF,  32'h0,        32'h200, 2};
        vecs[3] = '{1'b1, 2'b00, 3'b000, 32'h201, 32'h5A,       32'h0,      2, 32'h000080FF, 4'b0010, 32'h5A5A5A5A, 32'h200, 3};
        vecs[4] = '{1'b0, 2'b01, 3'b001, 32'h106, 32'h0,        32'h80FF1234, 2, 32'hFFFF80FF, 4'hF,  32'h0,        32'h104, 3};
        vecs[5] = '{1'b0, 2'b01, 3'b100, 32'h301, 32'h0,        32'h80FF1234, 1, 32'h00000012, 4'hF,  32'h0,        32'h300, 2};
        vecs[6] = '{1'b1, 2'b00, 3'b001, 32'h402, 32'h1234ABCD, 32'h0,      1, 32'h00000012, 4'b1100, 32'hABCDABCD, 32'h400, 2};
        vecs[7] = '{1'b0, 2'b01, 3'b010, 32'h500, 32'h0,        32'hCAFEF00D, 4, 32'hCAFEF00D, 4'hF,  32'h0,        32'h500, 5};
        vecs[8] = '{1'b1, 2'b01, 3'b010, 32'h504, 32'h11223344, 32'hFFFFFFFF, 1, 32'hCAFEF00D, 4'hF,  32'h11223344, 32'h504, 2};

        reset = 1'b1; MemWriteM = 1'b0; ResultSrcM = 2'b00; funct3M = '0; ALUResultM = '0;
        WriteDataM = '0; mem_rdata = '0; mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk); #1;
        check("rst_rdata", ReadDataM, 32'h0);
        check("rst_req", {31'd0, mem_req}, 32'h0);
        check("rst_we", {31'd0, mem_we}, 32'h0);
        check("rst_addr", mem_addr, 32'h0);
        check("rst_wdata", mem_wdata, 32'h0);
        check("rst_be", {28'd0, mem_be}, 32'h0);
        check("rst_bus_err", {31'd0, bus_err}, 32'h0);
        check("rst_misalign", {31'd0, misalign}, 32'h0);
        check("rst_stall", {31'd0, StallM}, 32'h0);
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            do_access(vecs[i].we, vecs[i].rs, vecs[i].f3, vecs[i].a, vecs[i].wd, vecs[i].rd,
                      vecs[i].lat, stalls, reqs, be, wdv, addrv, mis);
            check($sformatf("vec%0d_rdata", i), ReadDataM, vecs[i].exp_rd);
            check($sformatf("vec%0d_be", i), {28'd0, be}, {28'd0, vecs[i].exp_be});
            check($sformatf("vec%0d_addr", i), addrv, vecs[i].exp_addr);
            check($sformatf("vec%0d_stalls", i), stalls, vecs[i].exp_stalls);
            check($sformatf("vec%0d_req_idle", i), {31'd0, mem_req}, 32'h0);
            if (vecs[i].we) check($sformatf("vec%0d_wdata", i), wdv, vecs[i].exp_wd);
        end

        // Ack while idle must be ignored.
        mem_rdata = 32'h13579BDF; mem_ack = 1'b1;
        @(negedge clk); mem_ack = 1'b0; #1;
        check("idle_ack_rdata", ReadDataM, 32'hCAFEF00D);
        check("idle_ack_stall", {31'd0, StallM}, 32'h0);
        @(negedge clk);

        // LW at 0x102: trapped or silently aligned depending on build.
        do_access(1'b0, 2'b01, 3'b010, 32'h102, 32'h0, 32'h0BADF00D, 1, stalls, reqs, be, wdv, addrv, mis);
`ifdef PL_MEM_MISALIGN_TRAP_EN
        check("mis_stalls", stalls, 1);
        check("mis_reqs", reqs, 0);
        check("mis_pulse", {31'd0, mis}, 32'h1);
        check("mis_rdata", ReadDataM, 32'h0);
`else
        check("mis_stalls", stalls, 2);
        check("mis_addr", addrv, 32'h100);
        check("mis_pulse", {31'd0, mis}, 32'h0);
        check("mis_rdata", ReadDataM, 32'h0BADF00D);
`endif

        // Hung memory: watchdog aborts after 16 BUSY cycles.
        do_access(1'b0, 2'b01, 3'b010, 32'h600, 32'h0, 32'h12345678, 0, stalls, reqs, be, wdv, addrv, mis);
        check("to_reqs", reqs, 16);
        check("to_stalls", stalls, 17);
        check("to_bus_err", {31'd0, bus_err}, 32'h1);
        check("to_rdata", ReadDataM, 32'h0);
        do_access(1'b0, 2'b01, 3'b100, 32'h601, 32'h0, 32'h0000AB00, 1, stalls, reqs, be, wdv, addrv, mis);
        check("post_to_rdata", ReadDataM, 32'h000000AB);
        check("post_to_bus_err_sticky", {31'd0, bus_err}, 32'h1);

        // Reset during BUSY: request drops at once, a late ack is ignored.
        MemWriteM = 1'b0; ResultSrcM = 2'b01; funct3M = 3'b010; ALUResultM = 32'h700;
        mem_rdata = 32'hFFFFFFFF; mem_ack = 1'b0;
        @(negedge clk); #1;
        check("rstb_req_busy", {31'd0, mem_req}, 32'h1);
        reset = 1'b1; #1;
        check("rstb_req_async", {31'd0, mem_req}, 32'h0);
        ResultSrcM = 2'b00;
        @(negedge clk); reset = 1'b0;
        @(negedge clk); mem_ack = 1'b1;
        @(negedge clk); mem_ack = 1'b0; #1;
        check("rstb_rdata", ReadDataM, 32'h0);
        check("rstb_req_after", {31'd0, mem_req}, 32'h0);
        check("rstb_bus_err_clr", {31'd0, bus_err}, 32'h0);
        @(negedge clk);

        mdl_rd = 32'h0;
        for (int n = 0; n < 40; n++) begin
            we  = 1'($urandom_range(0, 1));
            rs  = we ? 2'($urandom_range(0, 3)) : 2'b01;
            f3  = 3'($urandom_range(0, 7));
            a   = $urandom;
            wd  = $urandom;
            rd  = $urandom;
            lat = $urandom_range(1, 4);
            sz  = acc_size(we, f3);
            is_mis = (int'(a[1:0]) % sz) != 0;
            do_access(we, rs, f3, a, wd, rd, lat, stalls, reqs, be, wdv, addrv, mis);
`ifdef PL_MEM_MISALIGN_TRAP_EN
            if (is_mis) begin
                mdl_rd = 32'h0;
                check($sformatf("rnd%0d_stalls", n), stalls, 1);
                check($sformatf("rnd%0d_reqs", n), reqs, 0);
                check($sformatf("rnd%0d_mis", n), {31'd0, mis}, 32'h1);
                check($sformatf("rnd%0d_rdata", n), ReadDataM, mdl_rd);
                continue;
            end
`endif
            check($sformatf("rnd%0d_mis", n), {31'd0, mis}, 32'h0);
            check($sformatf("rnd%0d_stalls", n), stalls, lat + 1);
            check($sformatf("rnd%0d_addr", n), addrv, a & 32'hFFFFFFFC);
            if (we) begin
                ref_store(f3, a, wd, m_be, m_wd);
                check($sformatf("rnd%0d_be", n), {28'd0, be}, {28'd0, m_be});
                check($sformatf("rnd%0d_wdata", n), wdv, m_wd);
            end else begin
                mdl_rd = ref_load(f3, a, rd);
                check($sformatf("rnd%0d_be", n), {28'd0, be}, 32'hF);
            end
            check($sformatf("rnd%0d_rdata", n), ReadDataM, mdl_rd);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pl_mem_stage.md
Name: pl_mem_stage

Overview:
- Memory-access stage between the execute|memory pipeline register and the memory|writeback register.
- Consumes ALUResultM, WriteDataM, funct3M, MemWriteM and ResultSrcM; runs a req/ack transaction with a variable-latency data memory.
- Produces an aligned, sign/zero-extended ReadDataM and a StallM that freezes the upstream pipeline until the access completes.
- Adds a watchdog timeout that flags a bus error on a hung memory.

Parameters:
- XLEN, 32, data/address width; only 32 is supported.
- TIMEOUT_CYCLES, 16, number of BUSY cycles without ack before abort; 0 disables the watchdog.
- CNT_W, 5, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- ALUResultM  in  32  effective address
- WriteDataM  in  32  store data (rs2)
- funct3M  in  3  access size/sign
- MemWriteM  in  1  store request
- ResultSrcM  in  2  2'b01 = load
- ReadDataM  out  32  formatted load data, registered
- StallM  out  1  high while an access is outstanding
- mem_req  out  1  memory request, registered
- mem_we  out  1  write enable
- mem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- mem_wdata  out  32  lane-replicated store data
- mem_be  out  4  byte enables
- mem_rdata  in  32  read data, valid with mem_ack
- mem_ack  in  1  single-cycle completion pulse
- bus_err  out  1  sticky timeout flag
- misalign  out  1  one-cycle misaligned-access pulse (feature only; tied 0 otherwise)

Behaviour:
- Reset: state=IDLE; ReadDataM=0; mem_req=0; mem_we=0; mem_addr=0; mem_wdata=0; mem_be=0; bus_err=0; misalign=0; counter=0.
- access = MemWriteM | (ResultSrcM==2'b01). A load with MemWriteM also set is treated as a store.
- StallM = access & (state!=DONE). Combinational; depends on state, MemWriteM and ResultSrcM only.
- IDLE, access high: register mem_req=1, mem_we, mem_addr, mem_wdata, mem_be; clear counter; go to BUSY.
- IDLE, no access: stay in IDLE; mem_req=0.
- BUSY: hold every mem_* output stable. Counter increments each cycle.
- BUSY, mem_ack: mem_req=0; capture the formatted mem_rdata into ReadDataM (stores leave ReadDataM unchanged); go to DONE.
- BUSY timeout: if TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1 with no ack: mem_req=0; bus_err<=1 (sticky until reset); ReadDataM=0; go to DONE. An ack in that same cycle wins over the timeout.
- DONE: StallM=0, so the pipeline advances on this edge; go to IDLE unconditionally. A back-to-back access is recognised in the following IDLE cycle.
- Minimum latency: 2 stall cycles with ack on the first BUSY cycle; total of 3 cycles in the M stage.
- mem_ack while IDLE or DONE: ignored.
- Stores:
  - SB: be=4'b0001<<a[1:0]; wdata={4{rs2[7:0]}}.
  - SH: be=4'b0011<<{a[1],1'b0}; wdata={2{rs2[15:0]}}.
  - SW and other funct3: be=4'hF; wdata=rs2.
- Loads:
  - LB/LBU select byte a[1:0], then sign/zero extend.
  - LH/LHU select half a[1], then sign/zero extend.
  - LW and funct3 011/110/111 return the full word.
- Loads assert mem_be=4'hF.
- Misaligned means: half access with a[0]=1, or word access with a[1:0]!=0.
- Reset mid-transaction: mem_req drops immediately (asynchronous); a later ack is ignored.

Optional Feature:
- Macro: PL_MEM_MISALIGN_TRAP_EN.
- Defined:
  - A misaligned access goes IDLE->DONE with no memory request.
  - Stores are suppressed; ReadDataM=0.
  - misalign pulses high for the DONE cycle.
- Undefined:
  - Misaligned addresses are silently aligned: half clears a[0], word clears a[1:0].
  - The access proceeds normally; the misalign port is tied 0.

Decomposition:
- Shared package pl_mem_pkg:
  - FSM state enum IDLE/BUSY/DONE.
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - RESULT_SRC_MEM=2'b01.
- One combinational sub-module pl_mem_fmt handles store lane steering/byte enables and load extraction/extension, so it can be unit-tested separately.

Test Plan:
- SW a=0x100, rs2=0xDEADBEEF, ack after 3 cycles -> mem_be=F, mem_wdata=0xDEADBEEF, mem_addr=0x100; StallM high 4 cycles; returns to IDLE.
- LB a=0x203, mem_rdata=0x80FF1234, immediate ack -> ReadDataM=0xFFFFFF80; StallM high exactly 2 cycles.
- LHU a=0x202, mem_rdata=0x80FF1234 -> ReadDataM=0x000080FF. SB a=0x201, rs2=0x5A -> be=4'b0010, wdata=0x5A5A5A5A.
- Load with no ack, TIMEOUT_CYCLES=16 -> mem_req drops after 16 BUSY cycles; bus_err=1 and stays 1; ReadDataM=0; pipeline resumes.
- Reset asserted during BUSY -> mem_req=0 the same cycle; an ack 2 cycles later causes no ReadDataM change.
- LW a=0x102 -> with the feature: no mem_req, misalign pulse, 1 stall cycle; without it: mem_addr=0x100 and normal completion.
